// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcodes, instruction formats and loader FSM states shared by the encoder.
package riscv_pkg;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_INV} fmt_t;

    typedef enum logic [1:0] {OCIOSO, ATIVO, CHEIO} estado_t;
endpackage

// File: rtl/codificador_campos.sv
// codificador_campos: packs decoded RV32I fields into an instruction word and checks the immediate range.
module codificador_campos
    import riscv_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output fmt_t        fmt,
    output logic        imm_ok
);
    logic cabe_12, cabe_13;

    always_comb begin
        fmt = opcode == OP_R ? FMT_R :
              (opcode == OP_IMM || opcode == OP_LOAD || opcode == OP_JALR) ? FMT_I :
              opcode == OP_STORE ? FMT_S :
              opcode == OP_BRANCH ? FMT_B : FMT_INV;
        cabe_12 = &imm[31:11] || ~|imm[31:11];
        // branch offsets are halfword aligned, so bit 0 must be clear
        cabe_13 = (&imm[31:12] || ~|imm[31:12]) && !imm[0];
        imm_ok = (fmt == FMT_I || fmt == FMT_S) ? cabe_12 :
                 fmt == FMT_B ? cabe_13 : 1'b1;
        instr = fmt == FMT_R ? {funct7, rs2, rs1, funct3, rd, opcode} :
                fmt == FMT_I ? {imm[11:0], rs1, funct3, rd, opcode} :
                fmt == FMT_S ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode} :
                fmt == FMT_B ? {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode} :
                32'd0;
    end
endmodule

// File: rtl/montador_instrucao.sv
// montador_instrucao: streaming RV32I encoder emitting address-tagged words for instruction memory load.
module montador_instrucao
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic              err_imm,
    output logic              err_opcode,
    output logic [ADDR_W:0]   word_count
);
    localparam logic [ADDR_W:0] ULTIMO = (ADDR_W + 1)'(DEPTH - 1);

    estado_t     estado, proximo;
    logic [31:0] instr;
    fmt_t        fmt;
    logic        imm_ok, xfer, legal, partida;

    codificador_campos u_cod (
        .opcode (in_opcode),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .imm    (in_imm),
        .instr  (instr),
        .fmt    (fmt),
        .imm_ok (imm_ok)
    );

    always_comb begin
        in_ready = estado == ATIVO && (!out_valid || out_ready);
        xfer     = in_valid && in_ready;
        legal    = fmt != FMT_INV && imm_ok;
        partida  = start && !out_valid && estado != ATIVO;
        proximo  = partida ? ATIVO :
                   (xfer && legal && word_count == ULTIMO) ? CHEIO : estado;
        busy     = estado == ATIVO;
        done     = estado == CHEIO;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            estado <= OCIOSO;
        else
            estado <= proximo;

    // word_count doubles as the address counter: both advance only on legal words
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_instr  <= '0;
            out_addr   <= '0;
            word_count <= '0;
            err_imm    <= 1'b0;
            err_opcode <= 1'b0;
        end else begin
            out_valid <= (xfer && legal) ? 1'b1 : out_ready ? 1'b0 : out_valid;
            if (xfer && legal) begin
                out_instr <= instr;
                out_addr  <= word_count[ADDR_W-1:0];
            end
            word_count <= partida ? '0 : word_count + {{ADDR_W{1'b0}}, xfer && legal};
            err_imm    <= !partida && (err_imm || (xfer && fmt != FMT_INV && !imm_ok));
            err_opcode <= !partida && (err_opcode || (xfer && fmt == FMT_INV));
        end
endmodule

// File: tb/tb_montador_instrucao.sv
// tb_montador_instrucao: randomized scoreboard bench with an arithmetic reference encoder.
module tb_montador_instrucao;
    localparam int AW = 2;
    localparam int DP = 4;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [6:0]    in_opcode = '0, in_funct7 = '0;
    logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]    in_funct3 = '0;
    logic [31:0]   in_imm = '0;
    logic          in_ready, out_valid, busy, done, err_imm, err_opcode;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_addr;
    logic [AW:0]   word_count;

    montador_instrucao #(.ADDR_W(AW), .DEPTH(DP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
        .busy(busy), .done(done), .err_imm(err_imm), .err_opcode(err_opcode), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] w; logic [AW-1:0] a;} exp_t;
    exp_t q[$];
    int   vectors = 0, miscompares = 0;
    int   ready_mode = 2;
    int   mstate = 0, mcount = 0;
    logic merr_imm = 1'b0, merr_op = 1'b0;

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nome, got, want, $time);
        end
    endtask

    // reference encoder: fields placed by shifting, legality by signed range
    function automatic void ref_enc(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                    input logic [31:0] imm, output logic ok, output logic bad,
                                    output logic [31:0] w);
        int v;
        logic [31:0] base;
        v    = int'($signed(imm));
        base = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        ok = 1'b1; bad = 1'b0; w = '0;
        case (op)
            7'b0110011: w = (32'(f7) << 25) | (32'(rs2) << 20) | base | (32'(rd) << 7);
            7'b0010011, 7'b0000011, 7'b1100111: begin
                ok = v >= -2048 && v <= 2047;
                w  = ((imm & 32'hfff) << 20) | base | (32'(rd) << 7);
            end
            7'b0100011: begin
                ok = v >= -2048 && v <= 2047;
                w  = (((imm >> 5) & 32'h7f) << 25) | (32'(rs2) << 20) | base | ((imm & 32'h1f) << 7);
            end
            7'b1100011: begin
                ok = v >= -4096 && v <= 4094 && (v & 1) == 0;
                w  = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3f) << 25) | (32'(rs2) << 20) |
                     base | (((imm >> 1) & 32'hf) << 8) | (((imm >> 11) & 32'h1) << 7);
            end
            default: begin ok = 1'b0; bad = 1'b1; end
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        out_ready = ready_mode == 0 ? $urandom_range(0, 3) != 0 : ready_mode == 2;
    end

    always @(negedge clk) if (rst_n) begin
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(mstate == 1 && (q.size() == 0 || out_ready)));
        chk("busy", 32'(busy), 32'(mstate == 1));
        chk("done", 32'(done), 32'(mstate == 2));
        chk("err_imm", 32'(err_imm), 32'(merr_imm));
        chk("err_opcode", 32'(err_opcode), 32'(merr_op));
        chk("word_count", 32'(word_count), mcount);
        if (out_valid && q.size() != 0) begin
            chk("out_instr", out_instr, q[0].w);
            chk("out_addr", 32'(out_addr), 32'(q[0].a));
            if (out_ready) void'(q.pop_front());
        end
    end

    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
        int guard = 0;
        logic pronto, ok, bad;
        logic [31:0] w;
        in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
        @(negedge clk) pronto = in_ready;
        while (!pronto && guard < 100) begin
            @(negedge clk) pronto = in_ready;
            guard++;
        end
        if (!pronto) begin
            chk("send_timeout", 32'(pronto), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        ref_enc(op, rd, rs1, rs2, f3, f7, imm, ok, bad, w);
        if (ok) begin
            q.push_back('{w, mcount[AW-1:0]});
            if (mcount == DP - 1) mstate = 2;
            mcount++;
        end else if (bad) merr_op = 1'b1;
        else merr_imm = 1'b1;
        #1 in_valid = 1'b0;
    endtask

    task automatic do_start();
        int guard = 0;
        while (q.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        chk("drain_before_start", 32'(q.size()), 32'd0);
        #1 start = 1'b1;
        @(posedge clk);
        if (mstate != 1) begin
            mstate = 1; mcount = 0; merr_imm = 1'b0; merr_op = 1'b0;
        end
        #1 start = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_instr"}, out_instr, 0);
        chk({tag, "_out_addr"}, 32'(out_addr), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err_imm"}, 32'(err_imm), 0);
        chk({tag, "_err_opcode"}, 32'(err_opcode), 0);
        chk({tag, "_word_count"}, 32'(word_count), 0);
    endtask

    logic [6:0] ops [7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                            7'b0100011, 7'b1100011, 7'b0110111};
    int bordas [10] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4098, 6};

    initial begin
        #12 chk_zero("reset");
        @(posedge clk) #1 rst_n = 1'b1;

        do_start();
        send(7'b0010011, 1, 0, 0, 3'b000, 0, 5);
        send(7'b0110011, 3, 1, 2, 3'b000, 0, 0);
        send(7'b0010011, 1, 0, 0, 3'b000, 0, 2048);
        send(7'b0000011, 2, 1, 0, 3'b010, 0, 8);
        send(7'b0100011, 0, 1, 2, 3'b010, 0, 12);
        repeat (3) @(posedge clk);

        do_start();
        ready_mode = 1;
        send(7'b0010011, 5, 6, 0, 3'b111, 0, -1);
        repeat (3) @(posedge clk);
        ready_mode = 2;
        #1;
        send(7'b0110011, 7, 8, 9, 3'b101, 7'b0100000, 0);
        send(7'b1100111, 1, 2, 0, 3'b000, 0, -2048);
        send(7'b0100011, 0, 3, 4, 3'b001, 0, 2047);
        repeat (3) @(posedge clk);

        do_start();
        send(7'b1100011, 0, 1, 2, 3'b000, 0, -8);
        send(7'b1100011, 0, 1, 2, 3'b001, 0, 6);
        send(7'b1100011, 0, 1, 2, 3'b000, 0, 5);
        send(7'b0110111, 4, 0, 0, 3'b000, 0, 0);

        ready_mode = 0;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] imm;
            int sel;
            if (mstate == 2 || $urandom_range(0, 19) == 0) do_start();
            sel = $urandom_range(0, 2);
            imm = sel == 0 ? 32'(bordas[$urandom_range(0, 9)]) :
                  sel == 1 ? 32'($urandom_range(0, 8191)) - 32'd4096 : 32'($urandom);
            send($urandom_range(0, 9) == 0 ? 7'($urandom) : ops[$urandom_range(0, 6)],
                 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), imm);
        end

        ready_mode = 2;
        do_start();
        if (mstate == 2) do_start();
        ready_mode = 1;
        send(7'b0010011, 9, 9, 0, 3'b000, 0, 100);
        @(negedge clk) #2 rst_n = 1'b0;
        q.delete(); mstate = 0; mcount = 0; merr_imm = 1'b0; merr_op = 1'b0;
        #1 chk_zero("async_reset");
        @(posedge clk) #1 rst_n = 1'b1;
        ready_mode = 2;
        do_start();
        send(7'b0010011, 1, 0, 0, 3'b000, 0, 5);
        repeat (4) @(posedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
